// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS pipeline.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats load, load only when decode is not stalled.
module if_id_register
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] new_instruction,
  input  logic [31:0] new_pc_plus4,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (load_enable && load) begin
      instruction <= new_instruction;
      pc_plus4    <= new_pc_plus4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, hold buffer for stalled responses,
// and the IF/ID register feeding decode.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        flush,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_pc_plus4,
  output logic        fd_valid,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic         deliver;
  logic [31:0]  deliver_data;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    deliver      = 1'b0;
    deliver_data = 32'h0;
    if (redirect) begin
      // Any response belonging to the old PC is stale from here on.
      pc_d   = redirect_target;
      hold_d = 32'h0;
      unique case (state_q)
        StIdle:    state_d = imem_ready  ? StDiscard : StIdle;
        StWait:    state_d = imem_rvalid ? StIdle    : StDiscard;
        StHold:    state_d = StIdle;
        StDiscard: state_d = imem_rvalid ? StIdle    : StDiscard;
        default:   state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (imem_ready) state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            if (load_enable) begin
              deliver      = 1'b1;
              deliver_data = imem_rdata;
              pc_d         = pc_plus4;
              state_d      = StIdle;
            end else begin
              hold_d  = imem_rdata;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (load_enable) begin
            deliver      = 1'b1;
            deliver_data = hold_q;
            pc_d         = pc_plus4;
            state_d      = StIdle;
          end
        end
        StDiscard: begin
          if (imem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_req   = (state_q == StIdle) && !rst;
  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == StWait) || (state_q == StDiscard);

  if_id_register u_if_id (
    .clk             (clk),
    .rst             (rst),
    .load_enable     (load_enable),
    .flush           (flush),
    .load            (deliver),
    .new_instruction (deliver_data),
    .new_pc_plus4    (pc_plus4),
    .instruction     (fd_instruction),
    .pc_plus4        (fd_pc_plus4),
    .valid           (fd_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory handshakes are driven by hand.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_enable;
  logic        flush;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] fd_instruction;
  logic [31:0] fd_pc_plus4;
  logic        fd_valid;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .load_enable    (load_enable),
    .flush          (flush),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .fd_instruction (fd_instruction),
    .fd_pc_plus4    (fd_pc_plus4),
    .fd_valid       (fd_valid),
    .fetch_busy     (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied before the posedge, outputs sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load_enable = 1'b1; flush = 1'b0;
    jump = 1'b0; jump_target = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", fd_instruction, 32'h0);
    chk("rst_pc4", fd_pc_plus4, 32'h0);
    chk("rst_valid", {31'h0, fd_valid}, 32'h0);
    chk("rst_busy", {31'h0, fetch_busy}, 32'h0);

    // First fetch at 0x0 with 1-cycle memory.
    rst = 1'b0;
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("wait_busy", {31'h0, fetch_busy}, 32'h1);
    chk("wait_noreq", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
    step();
    imem_rvalid = 1'b0;
    chk("d1_instr", fd_instruction, 32'h8C01_0004);
    chk("d1_pc4", fd_pc_plus4, 32'h4);
    chk("d1_valid", {31'h0, fd_valid}, 32'h1);
    chk("d1_next_addr", imem_addr, 32'h4);
    chk("d1_next_req", {31'h0, imem_req}, 32'h1);

    // Response arrives during a 3-cycle stall: buffered, delivered on release.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    load_enable = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2002_0005;
    step();
    imem_rvalid = 1'b0;
    step();
    step();
    chk("hold_instr", fd_instruction, 32'h8C01_0004);
    chk("hold_pc4", fd_pc_plus4, 32'h4);
    chk("hold_addr", imem_addr, 32'h4);
    chk("hold_noreq", {31'h0, imem_req}, 32'h0);
    chk("hold_busy", {31'h0, fetch_busy}, 32'h0);
    load_enable = 1'b1;
    step();
    chk("d2_instr", fd_instruction, 32'h2002_0005);
    chk("d2_pc4", fd_pc_plus4, 32'h8);
    chk("d2_addr", imem_addr, 32'h8);

    // Jump with flush while WAIT: stale response must be dropped.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    jump = 1'b1; jump_target = 32'h40; flush = 1'b1;
    step();
    jump = 1'b0; flush = 1'b0;
    chk("j_valid", {31'h0, fd_valid}, 32'h0);
    chk("j_instr", fd_instruction, 32'h0);
    chk("j_busy", {31'h0, fetch_busy}, 32'h1);
    chk("j_noreq", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("stale_valid", {31'h0, fd_valid}, 32'h0);
    chk("stale_instr", fd_instruction, 32'h0);
    chk("j_addr", imem_addr, 32'h40);
    chk("j_req", {31'h0, imem_req}, 32'h1);

    // Branch alone, then jump and branch together (jump wins).
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    step();
    chk("br_addr", imem_addr, 32'h0000_0200);
    jump = 1'b1; jump_target = 32'h40; branch_target = 32'h80;
    step();
    jump = 1'b0;
    chk("jb_addr", imem_addr, 32'h40);
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("br_wrap_addr", imem_addr, 32'hFFFF_FFFC);

    // Delivery at the top of the address space wraps PC+4.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_instr", fd_instruction, 32'h0000_0020);
    chk("wrap_pc4", fd_pc_plus4, 32'h0);
    chk("wrap_valid", {31'h0, fd_valid}, 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Flush beats stall and leaves PC/state alone.
    flush = 1'b1; load_enable = 1'b0;
    step();
    flush = 1'b0; load_enable = 1'b1;
    chk("fl_valid", {31'h0, fd_valid}, 32'h0);
    chk("fl_instr", fd_instruction, 32'h0);
    chk("fl_addr", imem_addr, 32'h0);
    chk("fl_req", {31'h0, imem_req}, 32'h1);

    // Deliver once more, then assert reset asynchronously mid-WAIT.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    chk("d3_pc4", fd_pc_plus4, 32'h4);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("pre_rst_busy", {31'h0, fetch_busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_instr", fd_instruction, 32'h0);
    chk("arst_pc4", fd_pc_plus4, 32'h0);
    chk("arst_valid", {31'h0, fd_valid}, 32'h0);
    chk("arst_busy", {31'h0, fetch_busy}, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the five-stage MIPS pipeline: owns the PC, issues single-outstanding requests to instruction memory, and owns the IF/ID pipeline register that feeds decode and the hazard detection unit. Consumes `load_enable` (stall) and `flush` from the hazard detection unit and the jump/branch redirect targets from decode. Delivers one instruction word plus its PC+4 to decode per accepted memory response.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `load_enable`  in  1  1 = IF/ID and PC may advance; 0 = stall
- `flush`  in  1  clear IF/ID to bubble this edge
- `jump`  in  1  redirect to `jump_target`
- `jump_target`  in  32  jump destination
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  32  branch destination
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address (= PC register)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  response instruction word
- `fd_instruction`  out  32  IF/ID instruction to decode
- `fd_pc_plus4`  out  32  IF/ID PC+4
- `fd_valid`  out  1  IF/ID holds a real instruction
- `fetch_busy`  out  1  response outstanding (state WAIT or DISCARD)

## Operation
- States: IDLE (request pending), WAIT (accepted, awaiting response), HOLD (response buffered, decode stalled), DISCARD (stale response outstanding).
- `imem_req` = 1 only in IDLE; `imem_addr` = PC, stable until `imem_ready`=1.
- IDLE: `imem_ready`=1 -> WAIT.
- WAIT, `imem_rvalid`=1: if `load_enable`=1 -> IF/ID <= {rdata, PC+4, valid=1}, PC <= PC+4, -> IDLE; else rdata into hold buffer, -> HOLD.
- HOLD: first cycle `load_enable`=1 -> hold buffer into IF/ID, PC <= PC+4, -> IDLE.
- Redirect = `jump` | `branch_taken`; target = `jump` ? `jump_target` : `branch_target` (jump wins). On redirect: PC <= target; hold buffer dropped; state: IDLE -> IDLE (or DISCARD if `imem_ready`=1 same cycle), WAIT -> DISCARD (or IDLE if `imem_rvalid`=1 same cycle, data dropped), HOLD -> IDLE, DISCARD -> DISCARD.
- DISCARD: `imem_rvalid`=1 -> data dropped, -> IDLE.
- `flush`=1 -> IF/ID <= {32'h0 (NOP), 0, valid=0}; flush overrides `load_enable`=0 and any same-cycle delivery. `flush` without redirect changes no PC or state.
- `load_enable`=0 and no flush -> IF/ID holds; PC holds except on redirect (redirect is honoured during stall).
- PC+4 wraps modulo 2^32.

## Timing
- Reset (async assert): PC=`RESET_PC`, state IDLE, hold buffer 0, `fd_instruction`=0, `fd_pc_plus4`=0, `fd_valid`=0, `fetch_busy`=0. `imem_req` forced 0 while `rst`=1; 1 on first cycle after deassert.
- Memory response latency ≥1 cycle after acceptance; one outstanding request maximum.
- Delivery: IF/ID updated on the edge sampling `imem_rvalid`=1 (no stall); next request the following cycle. Peak throughput one instruction per 2 cycles with 1-cycle memory.
- Redirect to new `imem_addr`: visible the cycle after the redirect edge (IDLE case), or the cycle after the stale response (DISCARD case).
- `rst` mid-transaction: state to IDLE; any in-flight response after deassert is ignored only if in DISCARD — memory must also be reset by the same `rst`.

## Structure
- Shared `cpu_pkg`: `NOP_INSTR` (32'h0), `RESET_PC_DEFAULT`, fetch state enum.
- One sub-module: `if_id_register` (IF/ID flops with load_enable/flush/valid priority); FSM, PC and hold buffer in the top.

## Test plan
- Reset release, 1-cycle memory returning 0x8C01_0004 @0x0 -> `imem_addr`=0x0, then IF/ID=0x8C01_0004, `fd_pc_plus4`=0x4, `fd_valid`=1, next `imem_addr`=0x4.
- Response while `load_enable`=0 for 3 cycles -> IF/ID unchanged, HOLD entered, delivered first cycle `load_enable`=1, PC 0x4->0x8.
- `jump`=1, target 0x40, while WAIT -> IF/ID cleared to NOP/valid=0, stale response dropped, next `imem_addr`=0x40.
- `jump`=1 (0x40) and `branch_taken`=1 (0x80) same cycle -> next fetch 0x40.
- `flush`=1 with `load_enable`=0 -> IF/ID = 0/valid 0 despite stall.
- PC=0xFFFF_FFFC delivery -> `fd_pc_plus4`=0x0, next `imem_addr`=0x0; async `rst` mid-WAIT -> all outputs to reset values immediately.
